// File: rtl/dmrfalu_sequencer_if.sv
// Handshake and datapath-control bundle between an instruction source and the sequencer.
// master drives start/instr/Zero; slave (the sequencer) drives the control strobes.
interface dmrfalu_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             start;
  logic [31:0]      instr;
  logic             Zero;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             branch_taken;
  logic [4:0]       Read1;
  logic [4:0]       Read2;
  logic [4:0]       WriteReg;
  logic [1:0]       ALUOp;
  logic [5:0]       FuncCode;
  logic             ALUSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             RegWrite;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, instr, Zero,
    input  busy, done, illegal, branch_taken, Read1, Read2, WriteReg, ALUOp, FuncCode,
    input  ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, retired
  );

  modport slave (
    input  start, instr, Zero,
    output busy, done, illegal, branch_taken, Read1, Read2, WriteReg, ALUOp, FuncCode,
    output ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, retired
  );
endinterface

// File: rtl/dmrfalu_sequencer.sv
// Multi-cycle MIPS control FSM: steps the DM/RF/ALU datapath through DECODE/EXEC/MEM/WB
// for one instruction per accepted start, and counts retired legal instructions.
module dmrfalu_sequencer #(
  parameter int unsigned CNT_W     = 16,
  parameter bit          IGNORE_R0 = 1'b1
) (
  input logic                clk,
  input logic                reset,
  dmrfalu_sequencer_if.slave bus
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb, StDone} state_e;

  typedef struct packed {
    logic [4:0] read1;
    logic [4:0] read2;
    logic [4:0] write_reg;
    logic [1:0] alu_op;
    logic [5:0] func_code;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } strobes_t;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic             taken_q, taken_d;
  logic             busy_q, done_q;
  strobes_t         out_q;
  logic [CNT_W-1:0] retired_q;
  logic             unused_shamt;

  function automatic logic is_rtype(logic [31:0] ir);
    return (ir[31:26] == OpRtype) &&
           (ir[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
  endfunction

  function automatic logic is_legal(logic [31:0] ir);
    return is_rtype(ir) || (ir[31:26] inside {OpLw, OpSw, OpBeq, OpAddi});
  endfunction

  // Moore decode of (state, ir); evaluated on the next state so outputs can be registered.
  function automatic strobes_t decode(state_e st, logic [31:0] ir);
    strobes_t   s;
    logic       r, lw, sw, beq, addi;
    s    = '0;
    r    = is_rtype(ir);
    lw   = (ir[31:26] == OpLw);
    sw   = (ir[31:26] == OpSw);
    beq  = (ir[31:26] == OpBeq);
    addi = (ir[31:26] == OpAddi);
    if (st inside {StDecode, StExec, StMem, StWb}) begin
      s.read1 = ir[25:21];
      s.read2 = ir[20:16];
    end
    if (st == StExec) begin
      s.alu_op = r ? 2'b10 : (beq ? 2'b01 : 2'b00);
      if (r) s.func_code = ir[5:0];
    end
    if ((st == StExec || st == StMem) && (lw || sw || addi)) s.alu_src = 1'b1;
    if (st == StMem) begin
      s.mem_read  = lw;
      s.mem_write = sw;
    end
    if (st == StWb) begin
      s.write_reg  = r ? ir[15:11] : ir[20:16];
      s.mem_to_reg = lw;
      s.reg_write  = !(IGNORE_R0 && (s.write_reg == 5'd0));
    end
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    taken_d   = taken_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StDecode;
          ir_d      = bus.instr;
          illegal_d = 1'b0;
          taken_d   = 1'b0;
        end
      end
      StDecode: begin
        if (!is_legal(ir_q)) begin
          state_d   = StDone;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (ir_q[31:26] == OpLw || ir_q[31:26] == OpSw) begin
          state_d = StMem;
        end else if (ir_q[31:26] == OpBeq) begin
          state_d = StDone;
          taken_d = bus.Zero;
        end else begin
          state_d = StWb;
        end
      end
      StMem:   state_d = (ir_q[31:26] == OpSw) ? StDone : StWb;
      StWb:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      taken_q   <= taken_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      out_q     <= decode(state_d, ir_d);
      if (state_q == StDone && !illegal_q) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign unused_shamt     = ^ir_q[10:6];

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;
  assign bus.branch_taken = taken_q;
  assign bus.Read1        = out_q.read1;
  assign bus.Read2        = out_q.read2;
  assign bus.WriteReg     = out_q.write_reg;
  assign bus.ALUOp        = out_q.alu_op;
  assign bus.FuncCode     = out_q.func_code;
  assign bus.ALUSrc       = out_q.alu_src;
  assign bus.MemRead      = out_q.mem_read;
  assign bus.MemWrite     = out_q.mem_write;
  assign bus.MemToReg     = out_q.mem_to_reg;
  assign bus.RegWrite     = out_q.reg_write;
  assign bus.retired      = retired_q;

endmodule

// File: tb/tb_dmrfalu_sequencer.sv
// Randomized self-checking bench for dmrfalu_sequencer against a phase-list reference model
// derived from the instruction class rules.
module tb_dmrfalu_sequencer;

  localparam int unsigned CntW = 16;

  typedef enum {KR, KLw, KSw, KBeq, KAddi, KIll} kind_e;
  typedef enum {PDec, PExec, PMem, PWb, PDone} phase_e;

  logic            clk = 1'b0;
  logic            reset;
  int unsigned     checks = 0;
  int unsigned     errors = 0;
  logic [CntW-1:0] model_retired = '0;
  logic [31:0]     obs;

  always #5 clk = ~clk;

  dmrfalu_sequencer_if #(.CNT_W(CntW)) bus ();

  dmrfalu_sequencer #(.CNT_W(CntW), .IGNORE_R0(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign obs = {2'b00, bus.busy, bus.done, bus.Read1, bus.Read2, bus.WriteReg, bus.ALUOp,
                bus.FuncCode, bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.MemToReg,
                bus.RegWrite};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic kind_e classify(logic [31:0] ins);
    int op;
    int fn;
    op = int'(ins >> 26);
    fn = int'(ins & 32'h3F);
    if (op == 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42)) return KR;
    case (op)
      35:      return KLw;
      43:      return KSw;
      4:       return KBeq;
      8:       return KAddi;
      default: return KIll;
    endcase
  endfunction

  // Expected output bundle while the instruction is in phase p.
  function automatic logic [31:0] expect_vec(phase_e p, logic [31:0] ins, kind_e k);
    logic [4:0] rs = ins[25:21];
    logic [4:0] rt = ins[20:16];
    logic [4:0] rd = ins[15:11];
    logic [4:0] r1 = 5'd0, r2 = 5'd0, wr = 5'd0;
    logic [1:0] op = 2'd0;
    logic [5:0] fc = 6'd0;
    logic       src, mr, mw, m2r, rw;
    if (p != PDone) begin
      r1 = rs;
      r2 = rt;
    end
    if (p == PExec) begin
      op = (k == KR) ? 2'd2 : ((k == KBeq) ? 2'd1 : 2'd0);
      if (k == KR) fc = ins[5:0];
    end
    src = (p == PExec || p == PMem) && (k == KLw || k == KSw || k == KAddi);
    mr  = (p == PMem) && (k == KLw);
    mw  = (p == PMem) && (k == KSw);
    m2r = (p == PWb) && (k == KLw);
    if (p == PWb) wr = (k == KR) ? rd : rt;
    rw  = (p == PWb) && (wr != 5'd0);
    return {2'b00, 1'b1, p == PDone, r1, r2, wr, op, fc, src, mr, mw, m2r, rw};
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_instr(input logic [31:0] ins, input logic z, input string name);
    kind_e  k;
    phase_e ph[$];
    k  = classify(ins);
    ph = {PDec};
    if (k != KIll) ph.push_back(PExec);
    if (k == KLw || k == KSw) ph.push_back(PMem);
    if (k == KR || k == KAddi || k == KLw) ph.push_back(PWb);
    ph.push_back(PDone);
    bus.start = 1'b1;
    bus.instr = ins;
    bus.Zero  = z;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("%s.cyc%0d", name, i + 1), 64'(obs), 64'(expect_vec(ph[i], ins, k)));
      if (ph[i] == PDone)
        check_eq($sformatf("%s.flags", name), 64'({bus.illegal, bus.branch_taken}),
                 64'({k == KIll, k == KBeq && z}));
      @(posedge clk);
      #1;
      // Junk start/instr while busy must be ignored; start must be low once back in idle.
      if (i < ph.size() - 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.instr = $urandom;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (k != KIll) model_retired = model_retired + 1'b1;
    @(negedge clk);
    check_eq({name, ".idle"}, 64'(obs), 64'd0);
    check_eq({name, ".retired"}, 64'(bus.retired), 64'(model_retired));
    check_eq({name, ".held"}, 64'({bus.illegal, bus.branch_taken}),
             64'({k == KIll, k == KBeq && z}));
  endtask

  // Abandon an instruction after `extra` edges beyond DECODE via a 2-cycle reset.
  task automatic reset_during(input logic [31:0] ins, input int extra, input string name);
    bus.start = 1'b1;
    bus.instr = ins;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (extra) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({name, ".strobes"}, 64'(obs), 64'd0);
    check_eq({name, ".retired"}, 64'(bus.retired), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_retired = '0;
    @(negedge clk);
    check_eq({name, ".after"}, 64'({obs, bus.illegal, bus.branch_taken}), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] ops[4] = '{6'h23, 6'h2B, 6'h04, 6'h08};
    logic [4:0] rs = 5'($urandom);
    logic [4:0] rt = 5'($urandom);
    logic [4:0] rd = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       return {6'h00, rs, rt, rd, 5'($urandom), fl[$urandom_range(0, 4)]};
      1:       return {ops[$urandom_range(0, 3)], rs, rt, 16'($urandom)};
      2:       return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.instr = '0;
    bus.Zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset.state", 64'({obs, bus.illegal, bus.branch_taken}), 64'd0);
    check_eq("reset.retired", 64'(bus.retired), 64'd0);

    reset_during(32'h8D280004, 2, "rst_lw_mem");

    run_instr(32'h012A4020, 1'b0, "add");
    run_instr(32'h8D280004, 1'b0, "lw");
    run_instr(32'hAD280004, 1'b1, "sw");
    run_instr(32'h11090003, 1'b1, "beq_t");
    run_instr(32'h11090003, 1'b0, "beq_nt");
    run_instr(32'hFC000000, 1'b1, "illegal");
    run_instr(32'h012A0020, 1'b0, "add_r0");
    run_instr(32'h2128FFFF, 1'b0, "addi");

    for (int n = 0; n < 60; n++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));

    reset_during(32'h012A4020, 2, "rst_add_wb");
    run_instr(32'h012A402A, 1'b0, "slt_post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
